// File: rtl/shift_4b_pkg.sv
// Shared types and sizes for the shift_4b datapath helper.
// Only WIDTH=4 is supported; the top checks this at elaboration.
package shift_4b_pkg;

  localparam int WIDTH   = 4;
  localparam int SHAMT_W = 2;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/shift_4b_comb.sv
// Combinational shift/rotate core for shift_4b.
// Port rot exists only when SHIFT_4B_ROTATE_EN is defined.
module shift_4b_comb
  import shift_4b_pkg::*;
(
  input  word_t              a,
  input  logic [SHAMT_W-1:0] shamt,
  input  dir_e               dir,
`ifdef SHIFT_4B_ROTATE_EN
  input  logic               rot,
`endif
  output word_t              next_y,
  output logic               next_carry
);

  logic               rot_on;
  logic [2*WIDTH-1:0] wide_l;
  logic [2*WIDTH-1:0] wide_r;
  logic [WIDTH:0]     ext_l;
  logic [WIDTH:0]     ext_r;

`ifdef SHIFT_4B_ROTATE_EN
  assign rot_on = rot;
`else
  assign rot_on = 1'b0;
`endif

  // Doubled word: one half holds the shift, the other the rotate.
  assign wide_l = {a, a} << shamt;
  assign wide_r = {a, a} >> shamt;

  // Guard bit catches the last bit out; zero when shamt=0.
  assign ext_l = {1'b0, a} << shamt;
  assign ext_r = {a, 1'b0} >> shamt;

  always_comb begin
    next_y     = a;
    next_carry = 1'b0;
    unique case (1'b1)
      (dir == DIR_LEFT) && !rot_on: begin
        next_y     = wide_l[WIDTH-1:0];
        next_carry = ext_l[WIDTH];
      end
      (dir == DIR_LEFT) && rot_on: begin
        next_y     = wide_l[2*WIDTH-1:WIDTH];
        next_carry = ext_l[WIDTH];
      end
      (dir == DIR_RIGHT) && !rot_on: begin
        next_y     = wide_r[2*WIDTH-1:WIDTH];
        next_carry = ext_r[0];
      end
      (dir == DIR_RIGHT) && rot_on: begin
        next_y     = wide_r[WIDTH-1:0];
        next_carry = ext_r[0];
      end
      default: begin
        next_y     = a;
        next_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_4b.sv
// Registered 4-bit barrel shifter, one edge of latency.
// Optional rotate mode via SHIFT_4B_ROTATE_EN (adds port rot).
module shift_4b
  import shift_4b_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
`ifdef SHIFT_4B_ROTATE_EN
  input  logic               rot,
`endif
  output logic [WIDTH-1:0]   y,
  output logic               carry,
  output logic               valid
);

  if (WIDTH != 4 || SHAMT_W != $clog2(WIDTH)) begin : g_width_check
    $error("shift_4b supports only WIDTH=4, SHAMT_W=2");
  end

  word_t next_y;
  logic  next_carry;

  shift_4b_comb u_comb (
    .a          (a),
    .shamt      (shamt),
    .dir        (dir_e'(dir)),
`ifdef SHIFT_4B_ROTATE_EN
    .rot        (rot),
`endif
    .next_y     (next_y),
    .next_carry (next_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y     <= '0;
      carry <= 1'b0;
      valid <= 1'b0;
    end else if (en) begin
      y     <= next_y;
      carry <= next_carry;
      valid <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_4b.sv
// Self-checking bench for shift_4b against an arithmetic model.
// Rotate steps are exercised when SHIFT_4B_ROTATE_EN is defined.
module tb_shift_4b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] a;
  logic [1:0] shamt;
  logic       dir;
  logic       rot;
  logic [3:0] y;
  logic       carry;
  logic       valid;

  int total = 0;
  int bad   = 0;

  logic [3:0] my;
  logic       mc;
  logic       mv;

  always #5 clk = ~clk;

  shift_4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .shamt (shamt),
    .dir   (dir),
`ifdef SHIFT_4B_ROTATE_EN
    .rot   (rot),
`endif
    .y     (y),
    .carry (carry),
    .valid (valid)
  );

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: multiply/divide by 2**s, wrap the lost bits for rotate.
  task automatic step(input logic r, input logic e,
                      input logic [3:0] av, input logic [1:0] s,
                      input logic d, input logic ro);
    int p, ny, nc, aa, si;
    logic ro_eff;
`ifdef SHIFT_4B_ROTATE_EN
    ro_eff = ro;
`else
    ro_eff = ro & 1'b0;
`endif
    @(negedge clk);
    rst_n = r; en = e; a = av; shamt = s; dir = d; rot = ro;
    aa = int'(av);
    si = int'(s);
    p  = 1 << si;
    if (!r) begin
      my = 4'd0; mc = 1'b0; mv = 1'b0;
    end else if (e) begin
      if (si == 0) begin
        ny = aa; nc = 0;
      end else if (!d) begin
        ny = (aa * p) % 16;
        nc = (aa >> (4 - si)) & 1;
        if (ro_eff) ny = ny + aa / (16 / p);
      end else begin
        ny = aa / p;
        nc = (aa >> (si - 1)) & 1;
        if (ro_eff) ny = ny + (aa % p) * (16 / p);
      end
      my = 4'(ny); mc = nc[0]; mv = 1'b1;
    end else begin
      mv = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("y", y, my);
    chk("carry", {3'b0, carry}, {3'b0, mc});
    chk("valid", {3'b0, valid}, {3'b0, mv});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; a = '0;
    shamt = '0; dir = 1'b0; rot = 1'b0;
    my = '0; mc = 1'b0; mv = 1'b0;

    step(0, 1, 4'b1111, 2'd1, 0, 0);
    chk("rst_y", y, 4'b0000);

    step(1, 1, 4'b0001, 2'd1, 0, 0);
    chk("l1_a", y, 4'b0010);
    step(1, 1, 4'b0011, 2'd1, 0, 0);
    chk("l1_b", y, 4'b0110);
    step(1, 1, 4'b1010, 2'd1, 0, 0);
    chk("l1_c", y, 4'b0100);
    chk("l1_c_carry", {3'b0, carry}, 4'd1);
    step(1, 1, 4'b1111, 2'd1, 0, 0);
    chk("l1_d", y, 4'b1110);

    step(1, 1, 4'b1011, 2'd2, 1, 0);
    chk("r2", y, 4'b0010);
    chk("r2_carry", {3'b0, carry}, 4'd1);
    step(1, 1, 4'b1011, 2'd0, 1, 0);
    chk("z0", y, 4'b1011);

    step(1, 1, 4'b0011, 2'd1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'(i + 5), 2'(i), 1, 0);
      chk("hold_y", y, 4'b0110);
    end

    step(1, 1, 4'b1111, 2'd1, 0, 0);
    step(0, 1, 4'b0101, 2'd1, 0, 0);
    chk("rst_mid", y, 4'b0000);
    step(1, 1, 4'b0101, 2'd2, 0, 0);
    chk("post_rst", y, 4'b0100);

`ifdef SHIFT_4B_ROTATE_EN
    step(1, 1, 4'b1010, 2'd1, 0, 1);
    chk("rotl", y, 4'b0101);
    step(1, 1, 4'b0001, 2'd3, 1, 1);
    chk("rotr", y, 4'b0010);
`endif

    for (int i = 0; i < 8; i++)
      step(1, 1, 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom));

    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 15) != 0), 1'($urandom),
           4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
